opctrl_vc_fifo: RTL and testbench

//  Parametrised router output-port controller, successor to the single-register opctrl.

---
 rtl/opctrl_vc_fifo.sv | 141 ++++++++++++++
 tb/tb_opctrl_vc_fifo.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/opctrl_vc_fifo.sv
// opctrl_vc_fifo: router output-port controller with two virtual-channel FIFOs.
//
// One granted input channel per cycle is written into the write VC, and the
// opposite VC is drained toward the downstream link. The ring polarity selects
// the VCs: polarity=0 writes VC0 and reads VC1, polarity=1 writes VC1 and reads VC0.
// Because of this, a single VC never sees a push and a pop in the same cycle.
//
// Ports:
//   clk             rising-edge clock
//   reset           synchronous, active-high; drops every queued flit
//   polarity        VC select (see above)
//   grant           one-hot grant from the arbiter; bit i selects data_in slice i
//   data_in         NUM_IN concatenated flits, slice i = [i*DATA_W +: DATA_W]
//   receive_output  downstream ready for a flit this cycle
//   data_out        registered flit to the link
//   send_output     registered valid for data_out, one cycle per flit
//   clear           combinational one-hot "flit taken" back to the granted input
//   empty / full    per-VC flags {VC1,VC0}, derived from the registered counts
//   grant_err       registered one-cycle pulse after a multi-hot grant
//
// Handshakes:
//   Upstream: a flit is taken in the cycle where clear[i] is high; when clear is
//   low, the input keeps its flit and must re-request.
//   Downstream: receive_output is a ready sampled at the clock edge. When it is
//   high and the read VC has a flit, that flit is popped at the edge and is
//   presented on data_out with send_output=1 for exactly one cycle. The
//   downstream must accept it because it has already signalled ready. When
//   send_output is low, data_out keeps its last value.
module opctrl_vc_fifo #(
  parameter int NUM_IN = 5,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     polarity,
  input  logic [NUM_IN-1:0]        grant,
  input  logic [NUM_IN*DATA_W-1:0] data_in,
  input  logic                     receive_output,
  output logic [DATA_W-1:0]        data_out,
  output logic                     send_output,
  output logic [NUM_IN-1:0]        clear,
  output logic [1:0]               empty,
  output logic [1:0]               full,
  output logic                     grant_err
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic              grant_multi;
  logic              grant_onehot;
  logic              wacc;
  logic              ren;
  logic [1:0]        push;
  logic [1:0]        pop;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] head [2];

  // grant & (grant-1) clears the lowest set bit. Any remaining bit means the
  // grant is multi-hot.
  assign grant_multi  = (grant & (grant - NUM_IN'(1))) != '0;
  assign grant_onehot = (grant != '0) && !grant_multi;

  assign wacc = grant_onehot && !full[polarity];
  assign ren  = receive_output && !empty[~polarity];

  assign push = wacc ? (polarity ? 2'b10 : 2'b01) : 2'b00;
  assign pop  = ren  ? (polarity ? 2'b01 : 2'b10) : 2'b00;

  assign clear = wacc ? grant : '0;

  // An AND-OR mux is enough because a write happens only with a one-hot grant.
  always_comb begin
    wr_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant[i]) begin
        wr_data = wr_data | data_in[i*DATA_W +: DATA_W];
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_vc
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    // The pointers wrap explicitly, so a DEPTH that is not a power of two
    // still uses every slot. Full and empty come from the count, not from
    // comparing the pointers.
    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[g]) begin
          wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
        end
        if (pop[g]) begin
          rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
        end
        if (push[g] && !pop[g]) begin
          count <= count + CNT_W'(1);
        end else if (pop[g] && !push[g]) begin
          count <= count - CNT_W'(1);
        end
      end
    end

    // The storage is not reset. After a reset, the zeroed count makes any
    // stale entries unreachable.
    always_ff @(posedge clk) begin
      if (push[g]) begin
        mem[wr_ptr] <= wr_data;
      end
    end

    assign head[g]  = mem[rd_ptr];
    assign empty[g] = (count == '0);
    assign full[g]  = (count == CNT_FULL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out    <= '0;
      send_output <= 1'b0;
      grant_err   <= 1'b0;
    end else begin
      send_output <= ren;
      grant_err   <= grant_multi;
      if (ren) begin
        data_out <= head[~polarity];
      end
    end
  end

endmodule

// File: tb/tb_opctrl_vc_fifo.sv
// tb_opctrl_vc_fifo: self-checking bench for opctrl_vc_fifo.
//
// A table of directed vectors covers the basic transfer, both VCs filling and
// draining, an illegal grant and pointer wrap. A reset sequence follows, then a
// random phase. Polarity toggles every cycle starting from 0 after each reset.
// A queue model of the two VCs feeds the expected-output queue, and every
// flit the DUT sends is popped from that queue and compared.
module tb_opctrl_vc_fifo;

  localparam int NUM_IN = 5;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 2;

  logic                     clk;
  logic                     reset;
  logic                     polarity;
  logic [NUM_IN-1:0]        grant;
  logic [NUM_IN*DATA_W-1:0] data_in;
  logic                     receive_output;
  logic [DATA_W-1:0]        data_out;
  logic                     send_output;
  logic [NUM_IN-1:0]        clear;
  logic [1:0]               empty;
  logic [1:0]               full;
  logic                     grant_err;

  opctrl_vc_fifo #(
    .NUM_IN (NUM_IN),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .polarity       (polarity),
    .grant          (grant),
    .data_in        (data_in),
    .receive_output (receive_output),
    .data_out       (data_out),
    .send_output    (send_output),
    .clear          (clear),
    .empty          (empty),
    .full           (full),
    .grant_err      (grant_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [NUM_IN-1:0] grant;
    logic              recv;
    logic [DATA_W-1:0] data;
    logic [NUM_IN-1:0] exp_clear;
    logic              exp_send;
    logic [1:0]        exp_empty;
    logic [1:0]        exp_full;
    logic              exp_err;
  } vec_t;

  localparam int NVEC = 27;
  vec_t vecs [NVEC];

  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] vq0 [$];
  logic [DATA_W-1:0] vq1 [$];
  logic              pol_r;
  logic [DATA_W-1:0] last_data;
  int                cmp_cnt;
  int                fail_cnt;

  function automatic vec_t mk(input logic [NUM_IN-1:0] g, input logic r,
                              input logic [DATA_W-1:0] d, input logic [NUM_IN-1:0] c,
                              input logic s, input logic [1:0] e, input logic [1:0] f,
                              input logic er);
    vec_t v;
    v.grant = g; v.recv = r; v.data = d; v.exp_clear = c;
    v.exp_send = s; v.exp_empty = e; v.exp_full = f; v.exp_err = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    grant = '0;
    receive_output = 1'b0;
    @(posedge clk);
    #1;
    check("rst_data_out", data_out, '0);
    check("rst_send", DATA_W'(send_output), '0);
    check("rst_empty", DATA_W'(empty), DATA_W'(2'b11));
    check("rst_full", DATA_W'(full), '0);
    check("rst_grant_err", DATA_W'(grant_err), '0);
    vq0.delete();
    vq1.delete();
    exp_q.delete();
    last_data = '0;
    pol_r = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_clear", DATA_W'(clear), '0);
  endtask

  // Drives one cycle of inputs and advances the model. When use_tab is set,
  // the control outputs are checked against the table entry; otherwise they
  // are checked against the model.
  task automatic step(input vec_t v, input logic use_tab);
    logic              onehot;
    logic              multi;
    logic              m_pop;
    logic [NUM_IN-1:0] m_clear;
    logic [1:0]        m_empty;
    logic [1:0]        m_full;
    logic [DATA_W-1:0] exp_d;
    @(negedge clk);
    polarity = pol_r;
    grant = v.grant;
    receive_output = v.recv;
    for (int i = 0; i < NUM_IN; i++) begin
      data_in[i*DATA_W +: DATA_W] = v.grant[i] ? v.data : {$urandom, $urandom};
    end
    onehot = ($countones(v.grant) == 1);
    multi = ($countones(v.grant) > 1);
    m_pop = 1'b0;
    m_clear = '0;
    if (v.recv) begin
      if (!pol_r && vq1.size() > 0) begin
        exp_q.push_back(vq1.pop_front());
        m_pop = 1'b1;
      end else if (pol_r && vq0.size() > 0) begin
        exp_q.push_back(vq0.pop_front());
        m_pop = 1'b1;
      end
    end
    if (onehot) begin
      if (!pol_r && vq0.size() < DEPTH) begin
        vq0.push_back(v.data);
        m_clear = v.grant;
      end else if (pol_r && vq1.size() < DEPTH) begin
        vq1.push_back(v.data);
        m_clear = v.grant;
      end
    end
    m_empty = {vq1.size() == 0, vq0.size() == 0};
    m_full = {vq1.size() == DEPTH, vq0.size() == DEPTH};
    #1;
    check("clear", DATA_W'(clear), DATA_W'(use_tab ? v.exp_clear : m_clear));
    @(posedge clk);
    #1;
    check("send_output", DATA_W'(send_output), DATA_W'(use_tab ? v.exp_send : m_pop));
    check("empty", DATA_W'(empty), DATA_W'(use_tab ? v.exp_empty : m_empty));
    check("full", DATA_W'(full), DATA_W'(use_tab ? v.exp_full : m_full));
    check("grant_err", DATA_W'(grant_err), DATA_W'(use_tab ? v.exp_err : multi));
    if (send_output) begin
      if (exp_q.size() == 0) begin
        cmp_cnt++;
        fail_cnt++;
        $display("FAIL data_out: unexpected send with %h, expected no flit", data_out);
      end else begin
        exp_d = exp_q.pop_front();
        check("data_out", data_out, exp_d);
        last_data = exp_d;
      end
    end else begin
      if (m_pop) exp_d = exp_q.pop_front();
      check("data_hold", data_out, last_data);
    end
    pol_r = ~pol_r;
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t rv;
    int   r;
    cmp_cnt = 0;
    fail_cnt = 0;
    reset = 1'b1;
    polarity = 1'b0;
    grant = '0;
    data_in = '0;
    receive_output = 1'b0;
    pol_r = 1'b0;
    last_data = '0;

    // basic transfer
    vecs[0]  = mk(5'b00001, 1, 64'hAAAA_AAAA_AAAA_AAAA, 5'b00001, 0, 2'b10, 2'b00, 0);
    vecs[1]  = mk(5'b00000, 1, 64'h0, 5'b00000, 1, 2'b11, 2'b00, 0);
    // fill both VCs while stalled, fifth grant refused, then drain
    vecs[2]  = mk(5'b00010, 0, 64'hBBBB_BBBB_BBBB_BBB0, 5'b00010, 0, 2'b10, 2'b00, 0);
    vecs[3]  = mk(5'b00010, 0, 64'hBBBB_BBBB_BBBB_BBB1, 5'b00010, 0, 2'b00, 2'b00, 0);
    vecs[4]  = mk(5'b00010, 0, 64'hBBBB_BBBB_BBBB_BBB2, 5'b00010, 0, 2'b00, 2'b01, 0);
    vecs[5]  = mk(5'b00010, 0, 64'hBBBB_BBBB_BBBB_BBB3, 5'b00010, 0, 2'b00, 2'b11, 0);
    vecs[6]  = mk(5'b00010, 0, 64'hBBBB_BBBB_BBBB_BBB4, 5'b00000, 0, 2'b00, 2'b11, 0);
    vecs[7]  = mk(5'b00000, 1, 64'h0, 5'b00000, 1, 2'b00, 2'b10, 0);
    vecs[8]  = mk(5'b00000, 1, 64'h0, 5'b00000, 1, 2'b00, 2'b00, 0);
    vecs[9]  = mk(5'b00000, 1, 64'h0, 5'b00000, 1, 2'b01, 2'b00, 0);
    vecs[10] = mk(5'b00000, 1, 64'h0, 5'b00000, 1, 2'b11, 2'b00, 0);
    vecs[11] = mk(5'b00000, 1, 64'h0, 5'b00000, 0, 2'b11, 2'b00, 0);
    // multi-hot grant, then idle
    vecs[12] = mk(5'b00110, 1, 64'hEEEE_EEEE_EEEE_EEEE, 5'b00000, 0, 2'b11, 2'b00, 1);
    vecs[13] = mk(5'b00000, 1, 64'h0, 5'b00000, 0, 2'b11, 2'b00, 0);
    // pointer wrap on VC0: C0..C4, alternating write and drain
    for (int k = 0; k < 5; k++) begin
      vecs[14 + 2*k] = mk(5'b00001, 1, 64'hC0C0_C0C0_C0C0_C000 + 64'(k),
                          5'b00001, 0, 2'b10, 2'b00, 0);
      vecs[15 + 2*k] = mk(5'b00000, 1, 64'h0, 5'b00000, 1, 2'b11, 2'b00, 0);
    end
    // fill VC0 ahead of the mid-traffic reset
    vecs[24] = mk(5'b00001, 0, 64'hD0D0_D0D0_D0D0_D000, 5'b00001, 0, 2'b10, 2'b00, 0);
    vecs[25] = mk(5'b00000, 0, 64'h0, 5'b00000, 0, 2'b10, 2'b00, 0);
    vecs[26] = mk(5'b00001, 0, 64'hD0D0_D0D0_D0D0_D001, 5'b00001, 0, 2'b10, 2'b01, 0);

    repeat (2) @(posedge clk);
    do_reset();

    for (int n = 0; n < NVEC; n++) begin
      step(vecs[n], 1'b1);
    end

    // reset with VC0 full: queued flits are dropped and nothing is sent
    do_reset();
    rv = mk(5'b00000, 1, 64'h0, 5'b00000, 0, 2'b11, 2'b00, 0);
    step(rv, 1'b1);
    step(rv, 1'b1);
    step(rv, 1'b1);

    // random traffic against the queue model
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r < 2) rv.grant = '0;
      else if (r < 9) rv.grant = NUM_IN'(1) << $urandom_range(0, NUM_IN - 1);
      else rv.grant = NUM_IN'(3) << $urandom_range(0, NUM_IN - 2);
      rv.recv = ($urandom_range(0, 3) != 0);
      rv.data = {$urandom, $urandom};
      step(rv, 1'b0);
    end

    // drain whatever is left
    rv = mk(5'b00000, 1, 64'h0, 5'b00000, 0, 2'b11, 2'b00, 0);
    for (int n = 0; n < 2*DEPTH + 2; n++) begin
      step(rv, 1'b0);
    end
    check("exp_q_drained", DATA_W'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
